// File: rtl/priority_decoder.sv
// -----------------------------------------------------------------------------
// priority_decoder
//   Turns a stream of priority codes back into request lines. Code 0 means
//   "no request"; code k (1..OUT_W) means request line k-1 is the highest one
//   active. Each accepted code is decoded to a one-hot vector, and the result
//   is presented through a registered valid/ready output stage.
//   In frame mode (acc_en=1 when a frame starts) every code in the frame is
//   ORed into one mask. The mask is emitted on the frame's last beat, together
//   with a saturating beat count.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   in_code/in_last valid
//   in_ready   beat accepted this cycle when in_valid is also high
//   in_code    priority code (0 = none)
//   in_last    last beat of frame (frame mode only)
//   acc_en     1 = frame mode, 0 = per-beat mode; sampled only in S_IDLE
//   out_valid  out_lines/out_count valid
//   out_ready  downstream accepts output
//   out_lines  decoded line vector (bit k-1 <-> code k)
//   out_count  beats in frame (1 in per-beat mode), saturating
// -----------------------------------------------------------------------------
module priority_decoder #(
   parameter int CODE_W = 2,
   parameter int OUT_W  = 3,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   input  logic              in_last,
   input  logic              acc_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_lines,
   output logic [CNT_W-1:0]  out_count
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_ACC  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // One-hot decode: bit i is set when the code equals i+1; code 0 decodes to 0.
   function automatic logic [OUT_W-1:0] dec(input logic [CODE_W-1:0] c);
      logic [OUT_W-1:0] v;
      for (int i = 0; i < OUT_W; i++) begin
         v[i] = (c == CODE_W'(i + 1));
      end
      return v;
   endfunction

   // Saturating increment: the counter sticks at its maximum value.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (x == CNT_MAX) ? x : (x + CNT_ONE);
   endfunction

   state_t           state_r;
   state_t           state_nx_s;
   logic [OUT_W-1:0] mask_r;
   logic [OUT_W-1:0] mask_nx_s;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_nx_s;
   logic             out_valid_r;
   logic [OUT_W-1:0] out_lines_r;
   logic [CNT_W-1:0] out_count_r;
   logic             load_s;
   logic [OUT_W-1:0] load_lines_s;
   logic [CNT_W-1:0] load_count_s;
   logic             in_ready_s;
   logic             accept_s;
   logic [OUT_W-1:0] dec_code_s;

   assign dec_code_s = dec(in_code);
   assign accept_s   = in_valid & in_ready_s;

   assign in_ready   = in_ready_s;
   assign out_valid  = out_valid_r;
   assign out_lines  = out_lines_r;
   assign out_count  = out_count_r;

   // Input ready: a mid-frame beat only touches the accumulator, so it never
   // waits for the output slot; beats that produce a result do.
   always_comb begin
      if (reset) begin
         in_ready_s = 1'b0;
      end else if ((state_r == S_ACC) && !in_last) begin
         in_ready_s = 1'b1;
      end else begin
         in_ready_s = !out_valid_r || out_ready;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic: a frame opens on a non-last frame-mode beat in S_IDLE
   // and closes on the accepted last beat.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s && acc_en && !in_last) begin
               state_nx_s = S_ACC;
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_ACC: begin
            if (accept_s && in_last) begin
               state_nx_s = S_IDLE;
            end else begin
               state_nx_s = S_ACC;
            end
         end
         default: begin
            state_nx_s = S_IDLE;
         end
      endcase
   end

   // Datapath control: accumulator updates and the result to load, if any.
   always_comb begin
      mask_nx_s    = mask_r;
      count_nx_s   = count_r;
      load_s       = 1'b0;
      load_lines_s = {OUT_W{1'b0}};
      load_count_s = {CNT_W{1'b0}};
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               if (acc_en && !in_last) begin
                  mask_nx_s  = dec_code_s;
                  count_nx_s = CNT_ONE;
               end else begin
                  // Per-beat mode, or a frame that is a single beat.
                  load_s       = 1'b1;
                  load_lines_s = dec_code_s;
                  load_count_s = CNT_ONE;
               end
            end else begin
               mask_nx_s = mask_r;
            end
         end
         S_ACC: begin
            if (accept_s) begin
               if (!in_last) begin
                  mask_nx_s  = mask_r | dec_code_s;
                  count_nx_s = sat_inc(count_r);
               end else begin
                  load_s       = 1'b1;
                  load_lines_s = mask_r | dec_code_s;
                  load_count_s = sat_inc(count_r);
                  mask_nx_s    = {OUT_W{1'b0}};
                  count_nx_s   = {CNT_W{1'b0}};
               end
            end else begin
               mask_nx_s = mask_r;
            end
         end
         default: begin
            mask_nx_s  = {OUT_W{1'b0}};
            count_nx_s = {CNT_W{1'b0}};
         end
      endcase
   end

   // Frame accumulator; a reset discards any partial frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         mask_r  <= {OUT_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else begin
         mask_r  <= mask_nx_s;
         count_r <= count_nx_s;
      end
   end

   // Output stage: a new result overwrites the slot (also on the handshake
   // cycle); otherwise the data holds and valid drops after the handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         out_lines_r <= {OUT_W{1'b0}};
         out_count_r <= {CNT_W{1'b0}};
      end else if (load_s) begin
         out_valid_r <= 1'b1;
         out_lines_r <= load_lines_s;
         out_count_r <= load_count_s;
      end else if (out_valid_r && out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

endmodule

// File: tb/tb_priority_decoder.sv
module tb_priority_decoder;

   localparam int CODE_W = 2;
   localparam int OUT_W  = 3;
   localparam int CNT_W  = 4;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [CODE_W-1:0] in_code;
   logic              in_last;
   logic              acc_en;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_lines;
   logic [CNT_W-1:0]  out_count;

   priority_decoder #(.CODE_W(CODE_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_code   (in_code),
      .in_last   (in_last),
      .acc_en    (acc_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_lines (out_lines),
      .out_count (out_count)
   );

   typedef struct {
      logic [OUT_W-1:0] lines;
      logic [CNT_W-1:0] count;
      int               acc;
      bit               exact;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   int total_cnt    = 0;
   int pass_cnt     = 0;
   int cyc          = 0;
   int last_acc_cyc = 0;
   int last_hs_cyc  = 0;
   int hs_bp        = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every output handshake pops one expected result.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_output: got lines=%b count=%0d expected none", out_lines, out_count);
         end else begin
            mon_e = sb_q.pop_front();
            check("out_lines", 32'(out_lines), 32'(mon_e.lines));
            check("out_count", 32'(out_count), 32'(mon_e.count));
            if (mon_e.exact) begin
               check("latency", 32'(cyc + 1 - mon_e.acc), 32'd1);
            end
         end
         last_hs_cyc = cyc + 1;
      end
   end

   // Drive one beat and hold it until accepted (bounded wait).
   task automatic send(input logic [1:0] code, input logic last, input logic acc,
                       input bit push, input logic [2:0] el, input logic [3:0] ec, input bit exact);
      bit   done;
      int   waited;
      exp_t e;
      in_valid = 1'b1;
      in_code  = code;
      in_last  = last;
      acc_en   = acc;
      done     = 1'b0;
      waited   = 0;
      while (!done && waited < 50) begin
         @(negedge clk);
         if (in_ready) begin
            done         = 1'b1;
            last_acc_cyc = cyc + 1;
            if (push) begin
               e.lines = el;
               e.count = ec;
               e.acc   = cyc + 1;
               e.exact = exact;
               sb_q.push_back(e);
            end
         end else begin
            waited++;
         end
      end
      if (!done) begin
         total_cnt++;
         $display("FAIL send_timeout: got no in_ready expected acceptance of code %0d", code);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_code  = 2'd0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Two reset cycles, checking the cleared state in each.
   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("rst_in_ready", 32'(in_ready), 32'd0);
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_out_lines", 32'(out_lines), 32'd0);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      in_valid  = 1'b0;
      in_code   = 2'd0;
      in_last   = 1'b0;
      acc_en    = 1'b0;
      out_ready = 1'b1;
      reset     = 1'b1;
      do_reset();

      // Per-beat, back-to-back codes 0..3.
      send(2'd0, 1'b0, 1'b0, 1'b1, 3'b000, 4'd1, 1'b1);
      send(2'd1, 1'b0, 1'b0, 1'b1, 3'b001, 4'd1, 1'b1);
      send(2'd2, 1'b0, 1'b0, 1'b1, 3'b010, 4'd1, 1'b1);
      send(2'd3, 1'b0, 1'b0, 1'b1, 3'b100, 4'd1, 1'b1);
      idle(3);

      // Frame: codes 1,0,3 -> 101, count 3.
      send(2'd1, 1'b0, 1'b1, 1'b0, 3'b000, 4'd0, 1'b0);
      send(2'd0, 1'b0, 1'b1, 1'b0, 3'b000, 4'd0, 1'b0);
      send(2'd3, 1'b1, 1'b1, 1'b1, 3'b101, 4'd3, 1'b1);
      idle(3);

      // Single-beat frame and an all-zero frame.
      send(2'd2, 1'b1, 1'b1, 1'b1, 3'b010, 4'd1, 1'b1);
      send(2'd0, 1'b0, 1'b1, 1'b0, 3'b000, 4'd0, 1'b0);
      send(2'd0, 1'b1, 1'b1, 1'b1, 3'b000, 4'd2, 1'b1);
      idle(3);

      // Backpressure: result held 5 cycles, next beat accepted on release.
      out_ready = 1'b0;
      send(2'd2, 1'b0, 1'b0, 1'b1, 3'b010, 4'd1, 1'b0);
      fork
         send(2'd1, 1'b0, 1'b0, 1'b1, 3'b001, 4'd1, 1'b1);
         begin
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               check("bp_in_ready", 32'(in_ready), 32'd0);
               check("bp_out_valid", 32'(out_valid), 32'd1);
               check("bp_out_lines", 32'(out_lines), 32'(3'b010));
               check("bp_out_count", 32'(out_count), 32'd1);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      hs_bp = last_hs_cyc;
      check("bp_same_cycle_accept", 32'(last_acc_cyc), 32'(hs_bp));
      idle(3);

      // Saturation: 20-beat frame of code 2 -> 010, count 15.
      for (int i = 0; i < 19; i++) begin
         send(2'd2, 1'b0, 1'b1, 1'b0, 3'b000, 4'd0, 1'b0);
      end
      send(2'd2, 1'b1, 1'b1, 1'b1, 3'b010, 4'd15, 1'b1);
      idle(3);

      // Reset while a result is pending: the result is dropped.
      out_ready = 1'b0;
      send(2'd3, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0, 1'b0);
      do_reset();
      out_ready = 1'b1;
      idle(2);

      // Reset mid-frame after 2 beats, then per-beat code 1 -> only 001.
      send(2'd3, 1'b0, 1'b1, 1'b0, 3'b000, 4'd0, 1'b0);
      send(2'd2, 1'b0, 1'b1, 1'b0, 3'b000, 4'd0, 1'b0);
      do_reset();
      send(2'd1, 1'b0, 1'b0, 1'b1, 3'b001, 4'd1, 1'b1);
      idle(5);

      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
